uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- Oversampling 8N1 UART receiver; the stage directly upstream of the joypad register block.
- Recovers bytes from the host USB-UART RX line and presents each one as a data byte plus a one-cycle strobe.
- The joypad block latches the byte on that strobe into its button state.
- Adds start-bit glitch rejection, mid-bit sampling, framing-error reporting and break handling.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per bit period (clock = baud × CLKS_PER_BIT, e.g. 16 × 460800 Hz). Legal values: 4 or more.
- HALF_BIT, CLKS_PER_BIT/2: cycles from the start-bit edge to the start-bit sample point.

Ports:
- clock  input  1  sampling clock.
- reset  input  1  synchronous reset, active-high.
- UART_RX  input  1  asynchronous serial line; idles at 1.
- data  output  8  last correctly framed byte, LSB received first.
- recv  output  1  one-cycle pulse: data has just been updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (sampled on the rising edge of clock while reset=1):
  - data=0, recv=0, frame_err=0, busy=0.
  - FSM=IDLE; both synchroniser flops=1; bit counter, shift register and cycle counter=0.
  - Reset overrides everything, including a frame in progress. No partial byte is ever output.
- Synchroniser: UART_RX passes through two flops to form rx_s, which lags the pin by 2 cycles. All decisions use rx_s only.
- Timing: let T be the first cycle in which rx_s=0 while in IDLE.
  - Start-bit sample at T+HALF_BIT.
  - Data bit i (i=0..7) sampled at T+HALF_BIT+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled at S = T+HALF_BIT+9·CLKS_PER_BIT.
  - recv or frame_err is high for exactly cycle S+1.
- FSM states:
  - IDLE: busy=0. rx_s=0 → START, cycle counter cleared.
  - START: at the HALF_BIT sample, rx_s=0 → DATA (bit index 0). rx_s=1 → IDLE, as a glitch: no outputs, no error.
  - DATA: every CLKS_PER_BIT cycles, shift rx_s into bit 7 of the shift register (right shift, LSB-first). After the 8th sample → STOP.
  - STOP at the stop-sample point:
    - rx_s=1: data←shift register, recv=1 for one cycle, → IDLE.
    - rx_s=0: frame_err=1 for one cycle, data unchanged, recv=0, → BREAK.
  - BREAK: busy=1. Wait for rx_s=1, then → IDLE. A line held low produces exactly one frame_err, with no repeats.
- Back-to-back frames:
  - The FSM returns to IDLE in cycle S+1.
  - A start edge appearing on rx_s from S+1 onward is detected.
  - A stop bit lasting exactly 1 bit period is sufficient for the next byte.
- recv and frame_err are never high in the same cycle, and each is never high for two consecutive cycles.
- data holds its value between frames and is stable whenever recv=1.
- Counters are sized as clog2(CLKS_PER_BIT) bits and never wrap mid-bit.
- No FIFO. A new byte overwrites data, and the consumer must sample on recv.

Test Plan (CLKS_PER_BIT=16, bit = 16 clocks):
1. Drive byte 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1). Required: data=0xA5; recv high for exactly one cycle, 2+8+144+1 = 155 cycles after the pin's falling edge; frame_err stays 0.
2. Drive UART_RX low for 4 clocks, then high. Required: busy pulses, then FSM returns to IDLE; recv=0, frame_err=0; data unchanged.
3. Send 0x3C with stop bit=0, then release the line high. Required: one frame_err pulse, recv=0, data keeps its previous value. The next valid byte 0x81 then gives data=0x81 with a recv pulse.
4. Hold UART_RX low for 40 bit periods, then high. Required: exactly one frame_err; busy=1 until rx_s returns high; then a normal byte 0x12 is received.
5. Send 0x00 then 0xFF back-to-back, each with a 1-bit stop. Required: two recv pulses exactly 160 cycles apart, with data=0x00 then 0xFF.
6. Assert reset at data bit 3 of a frame. Required: outputs 0 and busy=0 on the next cycle, no recv for the aborted frame; a following 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_oversampled_if.sv
// Byte-level output bundle of the oversampled UART receiver, as seen by the joypad register block.
interface uart_rx_oversampled_if;
    logic [7:0] data;
    logic       recv;
    logic       frame_err;
    logic       busy;

    modport master (output data, output recv, output frame_err, output busy);
    modport slave  (input  data, input  recv, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampling 8N1 UART receiver with start-bit glitch rejection, mid-bit sampling,
// framing-error reporting and break handling.
module uart_rx_oversampled #(
    parameter int CLKS_PER_BIT = 16,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          UART_RX,
    uart_rx_oversampled_if.master         rx_bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state;
    logic            sync_1;
    logic            rx_s;
    logic [CW-1:0]   cycle_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic [7:0]      data_r;
    logic            recv_r;
    logic            frame_err_r;
    logic            busy_r;

    // Counting restarts at every sample point, so the counter only ever spans one bit period.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            sync_1      <= 1'b1;
            rx_s        <= 1'b1;
            cycle_cnt   <= CNT_ZERO;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'h00;
            data_r      <= 8'h00;
            recv_r      <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            sync_1      <= UART_RX;
            rx_s        <= sync_1;
            recv_r      <= 1'b0;
            frame_err_r <= 1'b0;

            case (state)
                IDLE: begin
                    cycle_cnt <= CNT_ZERO;
                    bit_idx   <= 3'd0;
                    if (!rx_s) begin
                        state  <= START;
                        busy_r <= 1'b1;
                    end
                end

                START: begin
                    if (cycle_cnt == HALF_LAST) begin
                        cycle_cnt <= CNT_ZERO;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cycle_cnt == BIT_LAST) begin
                        cycle_cnt <= CNT_ZERO;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_ONE;
                    end
                end

                // A low stop bit reports once, then BREAK soaks up the rest of a held-low line.
                STOP: begin
                    if (cycle_cnt == BIT_LAST) begin
                        cycle_cnt <= CNT_ZERO;
                        if (rx_s) begin
                            data_r <= shift_reg;
                            recv_r <= 1'b1;
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end else begin
                            frame_err_r <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_ONE;
                    end
                end

                BREAK: begin
                    cycle_cnt <= CNT_ZERO;
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.data      = data_r;
    assign rx_bus.recv      = recv_r;
    assign rx_bus.frame_err = frame_err_r;
    assign rx_bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed self-checking bench for uart_rx_oversampled at 16 clocks per bit.
module tb_uart_rx_oversampled;

    logic clock;
    logic reset;
    logic UART_RX;
    int   cyc;
    int   checks;
    int   errors;

    int   recv_high;
    int   ferr_high;
    int   ferr_last_cyc;
    int   overlap_cnt;
    int   consec_recv;
    int   consec_ferr;
    logic prev_recv;
    logic prev_ferr;
    int   recv_cyc_q[$];
    logic [7:0] recv_data_q[$];
    int   fall_cyc;

    uart_rx_oversampled_if bus ();

    uart_rx_oversampled #(.CLKS_PER_BIT(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .UART_RX (UART_RX),
        .rx_bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // Pulse observer: records every output pulse with the cycle it was seen in.
    initial begin
        recv_high = 0; ferr_high = 0; ferr_last_cyc = -1;
        overlap_cnt = 0; consec_recv = 0; consec_ferr = 0;
        prev_recv = 1'b0; prev_ferr = 1'b0;
    end
    always @(negedge clock) begin
        if (bus.recv === 1'b1) begin
            recv_high = recv_high + 1;
            recv_cyc_q.push_back(cyc);
            recv_data_q.push_back(bus.data);
            if (prev_recv) consec_recv = consec_recv + 1;
        end
        if (bus.frame_err === 1'b1) begin
            ferr_high = ferr_high + 1;
            ferr_last_cyc = cyc;
            if (prev_ferr) consec_ferr = consec_ferr + 1;
        end
        if (bus.recv === 1'b1 && bus.frame_err === 1'b1) overlap_cnt = overlap_cnt + 1;
        prev_recv = bus.recv;
        prev_ferr = bus.frame_err;
    end

    task automatic idle_bits(input int n);
        UART_RX = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    // Caller is at a negedge; the start bit begins immediately.
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        UART_RX  = 1'b0;
        fall_cyc = cyc;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (16) @(negedge clock);
        end
        UART_RX = stop_val;
        repeat (16) @(negedge clock);
        UART_RX = 1'b1;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        UART_RX = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", bus.data); end
        checks++;
        if (bus.recv !== 1'b0) begin errors++; $display("[TB] FAIL reset_recv got %b want 0", bus.recv); end
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err got %b want 0", bus.frame_err); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        reset = 1'b0;
        idle_bits(32);
    endtask

    task automatic test_byte_a5;
        int r0, f0, q0;
        r0 = recv_high; f0 = ferr_high; q0 = recv_cyc_q.size();
        send_frame(8'hA5, 1'b1);
        idle_bits(32);
        checks++;
        if (recv_high - r0 !== 1) begin errors++; $display("[TB] FAIL a5_recv_cycles got %0d want 1", recv_high - r0); end
        checks++;
        if (recv_cyc_q.size() > q0 && recv_cyc_q[q0] !== fall_cyc + 155) begin
            errors++; $display("[TB] FAIL a5_recv_latency got %0d want %0d", recv_cyc_q[q0] - fall_cyc, 155);
        end
        checks++;
        if (bus.data !== 8'hA5) begin errors++; $display("[TB] FAIL a5_data got %h want a5", bus.data); end
        checks++;
        if (ferr_high - f0 !== 0) begin errors++; $display("[TB] FAIL a5_frame_err got %0d want 0", ferr_high - f0); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL a5_busy_idle got %b want 0", bus.busy); end
    endtask

    task automatic test_glitch;
        int r0, f0;
        r0 = recv_high; f0 = ferr_high;
        UART_RX = 1'b0;
        repeat (4) @(negedge clock);
        UART_RX = 1'b1;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy got %b want 1", bus.busy); end
        idle_bits(20);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_after got %b want 0", bus.busy); end
        checks++;
        if (recv_high - r0 !== 0 || ferr_high - f0 !== 0) begin
            errors++; $display("[TB] FAIL glitch_pulses got recv %0d ferr %0d want 0 0", recv_high - r0, ferr_high - f0);
        end
        checks++;
        if (bus.data !== 8'hA5) begin errors++; $display("[TB] FAIL glitch_data got %h want a5", bus.data); end
    endtask

    task automatic test_frame_error;
        int r0, f0;
        r0 = recv_high; f0 = ferr_high;
        send_frame(8'h3C, 1'b0);
        idle_bits(32);
        checks++;
        if (ferr_high - f0 !== 1) begin errors++; $display("[TB] FAIL ferr_count got %0d want 1", ferr_high - f0); end
        checks++;
        if (ferr_last_cyc !== fall_cyc + 155) begin
            errors++; $display("[TB] FAIL ferr_latency got %0d want %0d", ferr_last_cyc - fall_cyc, 155);
        end
        checks++;
        if (recv_high - r0 !== 0) begin errors++; $display("[TB] FAIL ferr_recv got %0d want 0", recv_high - r0); end
        checks++;
        if (bus.data !== 8'hA5) begin errors++; $display("[TB] FAIL ferr_data_kept got %h want a5", bus.data); end
        r0 = recv_high;
        send_frame(8'h81, 1'b1);
        idle_bits(32);
        checks++;
        if (bus.data !== 8'h81 || recv_high - r0 !== 1) begin
            errors++; $display("[TB] FAIL ferr_next_byte got data %h recv %0d want 81 1", bus.data, recv_high - r0);
        end
    endtask

    task automatic test_break;
        int r0, f0;
        r0 = recv_high; f0 = ferr_high;
        UART_RX  = 1'b0;
        fall_cyc = cyc;
        repeat (640) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL break_busy_low got %b want 1", bus.busy); end
        UART_RX = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL break_busy_release got %b want 0", bus.busy); end
        checks++;
        if (ferr_high - f0 !== 1 || recv_high - r0 !== 0) begin
            errors++; $display("[TB] FAIL break_pulses got ferr %0d recv %0d want 1 0", ferr_high - f0, recv_high - r0);
        end
        idle_bits(32);
        r0 = recv_high;
        send_frame(8'h12, 1'b1);
        idle_bits(32);
        checks++;
        if (bus.data !== 8'h12 || recv_high - r0 !== 1) begin
            errors++; $display("[TB] FAIL break_next_byte got data %h recv %0d want 12 1", bus.data, recv_high - r0);
        end
    endtask

    task automatic test_back_to_back;
        int q0;
        q0 = recv_cyc_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(32);
        checks++;
        if (recv_cyc_q.size() - q0 !== 2) begin
            errors++; $display("[TB] FAIL b2b_count got %0d want 2", recv_cyc_q.size() - q0);
        end else begin
            checks++;
            if (recv_cyc_q[q0 + 1] - recv_cyc_q[q0] !== 160) begin
                errors++; $display("[TB] FAIL b2b_spacing got %0d want 160", recv_cyc_q[q0 + 1] - recv_cyc_q[q0]);
            end
            checks++;
            if (recv_data_q[q0] !== 8'h00 || recv_data_q[q0 + 1] !== 8'hFF) begin
                errors++; $display("[TB] FAIL b2b_data got %h %h want 00 ff", recv_data_q[q0], recv_data_q[q0 + 1]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int r0;
        logic [7:0] b;
        b  = 8'hC3;
        r0 = recv_high;
        UART_RX = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            UART_RX = b[i];
            repeat (16) @(negedge clock);
        end
        UART_RX = b[3];
        repeat (6) @(negedge clock);
        reset   = 1'b1;
        UART_RX = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.data !== 8'h00 || bus.recv !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got data %h recv %b ferr %b busy %b want 00 0 0 0",
                     bus.data, bus.recv, bus.frame_err, bus.busy);
        end
        reset = 1'b0;
        idle_bits(200);
        checks++;
        if (recv_high - r0 !== 0) begin errors++; $display("[TB] FAIL midreset_no_recv got %0d want 0", recv_high - r0); end
        send_frame(8'h5A, 1'b1);
        idle_bits(32);
        checks++;
        if (bus.data !== 8'h5A || recv_high - r0 !== 1) begin
            errors++; $display("[TB] FAIL midreset_next_byte got data %h recv %0d want 5a 1", bus.data, recv_high - r0);
        end
    endtask

    task automatic test_pulse_rules;
        checks++;
        if (overlap_cnt !== 0) begin errors++; $display("[TB] FAIL pulse_overlap got %0d want 0", overlap_cnt); end
        checks++;
        if (consec_recv !== 0 || consec_ferr !== 0) begin
            errors++; $display("[TB] FAIL pulse_width got recv %0d ferr %0d want 0 0", consec_recv, consec_ferr);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        fall_cyc = 0;
        reset    = 1'b1;
        UART_RX  = 1'b1;
        @(negedge clock);
        test_reset();
        test_byte_a5();
        test_glitch();
        test_frame_error();
        test_break();
        test_back_to_back();
        test_reset_midframe();
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
